// File: rtl/serial_audio_pkg.sv
// Shared types and helpers for the serial audio codec interface (DAC serializer, ADC deserializer).
package serial_audio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ps_state_e;

  localparam int AUDIO_DATA_W = 32;

  // Width of a down-counter that must hold DATA_W-1; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/lrclk_edge_det.sv
// Frame-clock rising-edge detector: one-cycle pulse in the cycle lrclk first reads high.
// Latency: combinational pulse against one register stage; no backpressure.
module lrclk_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic lrclk,
  output logic rise
);

  logic lrclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrclk_q <= 1'b0;
    end else begin
      lrclk_q <= lrclk;
    end
  end

  assign rise = lrclk & ~lrclk_q;

endmodule

// File: rtl/parallel_serial.sv
// Parallel-to-serial DAC feeder: MSB first from the edge after an lrclk rise; sample_req one cycle after the LSB.
// One-entry hold register; ready drops the cycle after accept. Macro PARALLEL_SERIAL_UNDERRUN_MUTE_EN mutes underrun frames.
module parallel_serial
  import serial_audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrclk,
  input  logic [DATA_W-1:0] i_data_parallel_DAC,
  input  logic              i_data_valid,
  output logic              o_data_ready,
  output logic              o_data_serial_DAC,
  output logic              o_sample_req,
  output logic              o_busy,
  output logic              o_underrun,
  output logic              o_frame_err
);

  localparam int CW = cnt_w(DATA_W);

  ps_state_e         state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] last_q;
  logic              hold_full;
  logic              start;
  logic              accept;
  logic [DATA_W-1:0] load_val;

  lrclk_edge_det u_edge (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .lrclk (i_lrclk),
    .rise  (start)
  );

  assign o_data_ready = ~hold_full;
  assign accept       = i_data_valid & ~hold_full;
  assign o_busy       = (state != IDLE);

  // Sample loaded into the shifter at frame start; an empty hold register is an underrun.
  always_comb begin
    load_val = hold_q;
    if (!hold_full) begin
`ifdef PARALLEL_SERIAL_UNDERRUN_MUTE_EN
      load_val = '0;
`else
      load_val = last_q;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      shift_q           <= '0;
      hold_q            <= '0;
      last_q            <= '0;
      hold_full         <= 1'b0;
      o_data_serial_DAC <= 1'b0;
      o_sample_req      <= 1'b0;
      o_underrun        <= 1'b0;
      o_frame_err       <= 1'b0;
    end else begin
      o_sample_req <= 1'b0;
      o_underrun   <= 1'b0;
      o_frame_err  <= 1'b0;

      // accept and the start-time clear are exclusive: accept needs hold empty, the clear needs it full.
      if (accept) begin
        hold_q    <= i_data_parallel_DAC;
        hold_full <= 1'b1;
      end

      if (start && (state != IDLE)) begin
        o_frame_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state             <= SHIFT;
            shift_q           <= load_val;
            cnt               <= CW'(DATA_W - 1);
            o_data_serial_DAC <= load_val[DATA_W-1];
            if (hold_full) begin
              hold_full <= 1'b0;
              last_q    <= hold_q;
            end else begin
              o_underrun <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            shift_q           <= shift_q << 1;
            o_data_serial_DAC <= shift_q[DATA_W-2];
            cnt               <= cnt - 1'b1;
          end else begin
            state             <= DONE;
            o_data_serial_DAC <= 1'b0;
            o_sample_req      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_serial.sv
// Scoreboard bench for parallel_serial: expected frames queued at frame start, compared when sample_req appears.
module tb_parallel_serial;

  localparam int W = 32;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_lrclk = 1'b0;
  logic         i_data_valid = 1'b0;
  logic [W-1:0] i_data_parallel_DAC = '0;
  logic         o_data_ready;
  logic         o_data_serial_DAC;
  logic         o_sample_req;
  logic         o_busy;
  logic         o_underrun;
  logic         o_frame_err;

  parallel_serial #(.DATA_W(W)) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_lrclk             (i_lrclk),
    .i_data_parallel_DAC (i_data_parallel_DAC),
    .i_data_valid        (i_data_valid),
    .o_data_ready        (o_data_ready),
    .o_data_serial_DAC   (o_data_serial_DAC),
    .o_sample_req        (o_sample_req),
    .o_busy              (o_busy),
    .o_underrun          (o_underrun),
    .o_frame_err         (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [W-1:0] word;
    logic         und;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  int           req_cyc = 0;
  int           ferr_cnt = 0;
  int           nbits = 0;
  logic [W-1:0] acc = '0;
  logic         und_seen = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Deserialize the stream: bits are the busy cycles before sample_req; the sample_req cycle closes the frame.
  always @(negedge i_clk) begin
    if (o_frame_err) ferr_cnt++;
    if (!o_busy) begin
      nbits    = 0;
      acc      = '0;
      und_seen = 1'b0;
    end else if (!o_sample_req) begin
      acc = {acc[W-2:0], o_data_serial_DAC};
      nbits++;
      if (o_underrun) und_seen = 1'b1;
    end else begin
      req_cyc = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_frame", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("frame_word", acc, e.word);
        chk("frame_bits", nbits, W);
        chk("frame_underrun", {31'd0, und_seen}, {31'd0, e.und});
        chk("frame_serial_idle", {31'd0, o_data_serial_DAC}, 32'd0);
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [W-1:0] d);
    bit ok = 1'b0;
    @(posedge i_clk);
    #1;
    i_data_parallel_DAC = d;
    i_data_valid        = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (o_data_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge i_clk);
    #1 i_data_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Returns just after the posedge that detects the lrclk rise; lrclk is left high.
  task automatic start_frame(input logic [W-1:0] word, input logic und);
    exp_t x;
    wait_idle();
    @(posedge i_clk);
    #1 i_lrclk = 1'b0;
    @(posedge i_clk);
    #1 i_lrclk = 1'b1;
    x.word = word;
    x.und  = und;
    sb.push_back(x);
    @(posedge i_clk);
    #1 start_cyc = cyc;
  endtask

  logic [W-1:0] und_word;
  int           f0;

  initial begin
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", {31'd0, o_data_ready}, 32'd1);
    chk("rst_serial", {31'd0, o_data_serial_DAC}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_req", {31'd0, o_sample_req}, 32'd0);
    chk("rst_flags", {30'd0, o_underrun, o_frame_err}, 32'd0);
    i_rst_n = 1'b1;

    // Basic frame plus sample_req latency
    send(32'hA5A5_0F0F);
    start_frame(32'hA5A5_0F0F, 1'b0);
    wait_idle();
    chk("req_latency", req_cyc - start_cyc, W);

    // Loopback patterns, second sample loaded during the first frame
    send(32'h8000_0001);
    start_frame(32'h8000_0001, 1'b0);
    send(32'h7FFF_FFFE);
    start_frame(32'h7FFF_FFFE, 1'b0);

    // Underrun: second frame has no new sample
    send(32'h1234_5678);
    start_frame(32'h1234_5678, 1'b0);
`ifdef PARALLEL_SERIAL_UNDERRUN_MUTE_EN
    und_word = 32'h0;
`else
    und_word = 32'h1234_5678;
`endif
    start_frame(und_word, 1'b1);

    // Valid held while hold is full: one accept per frame
    send(32'h1111_2222);
    @(posedge i_clk);
    #1;
    i_data_parallel_DAC = 32'h3333_4444;
    i_data_valid        = 1'b1;
    repeat (5) @(negedge i_clk);
    chk("ready_full", {31'd0, o_data_ready}, 32'd0);
    start_frame(32'h1111_2222, 1'b0);
    @(negedge i_clk);
    chk("ready_after_start", {31'd0, o_data_ready}, 32'd1);
    @(negedge i_clk);
    chk("ready_refilled", {31'd0, o_data_ready}, 32'd0);
    @(posedge i_clk);
    #1 i_data_valid = 1'b0;
    start_frame(32'h3333_4444, 1'b0);

    // lrclk rise 10 cycles into a frame
    send(32'hCAFE_F00D);
    f0 = ferr_cnt;
    start_frame(32'hCAFE_F00D, 1'b0);
    repeat (3) @(posedge i_clk);
    #1 i_lrclk = 1'b0;
    repeat (6) @(posedge i_clk);
    #1 i_lrclk = 1'b1;
    wait_idle();
    chk("frame_err_count", ferr_cnt - f0, 32'd1);

    // Reset mid-frame discards the partial frame and the held sample
    send(32'hDEAD_BEEF);
    start_frame(32'hDEAD_BEEF, 1'b0);
    send(32'h5555_AAAA);
    repeat (12) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, o_busy}, 32'd0);
    chk("midrst_serial", {31'd0, o_data_serial_DAC}, 32'd0);
    chk("midrst_ready", {31'd0, o_data_ready}, 32'd1);
    chk("midrst_req", {31'd0, o_sample_req}, 32'd0);
    sb.delete();
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    start_frame(32'h0, 1'b1);
    wait_idle();

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule

// File: doc/parallel_serial.md
# parallel_serial

Transmit-side counterpart of the ADC deserializer. It accepts a 32-bit parallel sample from the filter/equalizer datapath through a valid/ready handshake and buffers it in a one-entry holding register. It then shifts the sample out MSB-first, one bit per `i_clk` cycle, to the serial DAC input, starting on each rising edge of `i_lrclk`. It sits between the equalizer output and the codec DAC pin.

## Interface
- `DATA_W`, default 32: sample width. It is also the number of bits per frame.
- `i_clk`  in  1  bit clock. All logic is on its posedge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_lrclk`  in  1  frame clock. A rising edge starts a frame.
- `i_data_parallel_DAC`  in  DATA_W  sample from the filter.
- `i_data_valid`  in  1  the sample on `i_data_parallel_DAC` is valid.
- `o_data_ready`  out  1  the holding register can accept a sample.
- `o_data_serial_DAC`  out  1  serial bit to the DAC.
- `o_sample_req`  out  1  one-cycle pulse after a frame completes. Requests the next filter sample.
- `o_busy`  out  1  a frame is in progress (state ≠ IDLE).
- `o_underrun`  out  1  one-cycle pulse. A frame started with the holding register empty.
- `o_frame_err`  out  1  one-cycle pulse. An `i_lrclk` rising edge arrived while state ≠ IDLE.

## Operation
- Reset values:
  - all state, counters, shift, holding and last-sent registers are 0;
  - state is IDLE;
  - `o_data_serial_DAC`, `o_sample_req`, `o_busy`, `o_underrun`, `o_frame_err` are 0;
  - `o_data_ready` is 1.
- Handshake:
  - `o_data_ready = ~hold_full`.
  - A transfer occurs on a posedge where `i_data_valid & o_data_ready`. It writes the holding register and sets `hold_full`.
  - `i_data_valid` without `o_data_ready` has no effect. The sender keeps the data stable.
- Edge detection: `lrclk_q` is `i_lrclk` registered. The start condition is `i_lrclk & ~lrclk_q`.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on start:
    - with `hold_full`: shifter and last-sent are loaded from hold; `hold_full` is cleared.
    - without `hold_full`: underrun. The shifter loads the last-sent sample and `o_underrun` pulses.
    - in both cases: bit counter = DATA_W−1, and `o_data_serial_DAC` is registered from the loaded MSB.
  - SHIFT, counter > 0: shift left by one, counter decrements, and `o_data_serial_DAC` takes the next bit.
  - SHIFT → DONE when counter = 0. `o_data_serial_DAC` becomes 0.
  - DONE → IDLE after one cycle. `o_sample_req` is 1 during DONE.
- Simultaneous events:
  - Underrun start and handshake in the same cycle: the accepted sample lands in hold for the next frame. It is not used in the current frame.
  - Start with hold full: `o_data_ready` is 0 that cycle, so no conflict.
  - A start edge in SHIFT or DONE is ignored and `o_frame_err` pulses. The frame in flight completes unaltered.
- Reset mid-frame: everything returns to its reset value immediately. The partial frame is abandoned and the held sample is discarded.
- Width rules:
  - The counter is `$clog2(DATA_W)` bits and never wraps below 0.
  - Shift-in fill is 0.

## Timing
- Start detected at posedge k: MSB visible after k, during cycles k+1. Bit DATA_W−1−n is valid after posedge k+n, for n = 0..DATA_W−1.
- LSB appears after posedge k+DATA_W−1. DONE follows at k+DATA_W, and `o_sample_req` is high for cycle k+DATA_W+1.
- The ADC receiver samples each bit one posedge later, giving a bit-aligned loopback.
- Minimum frame period is DATA_W+2 cycles. Shorter periods produce `o_frame_err`.
- Handshake acceptance to `o_data_ready` low: one cycle.

## Configuration
- `PARALLEL_SERIAL_UNDERRUN_MUTE_EN`:
  - Defined: an underrun frame transmits all zeros, and last-sent is not updated.
  - Undefined: an underrun frame repeats the last-sent sample.
  - `o_underrun` pulses in both cases.

## Structure
- Shared package `serial_audio_pkg` holds:
  - `ps_state_e` (IDLE, SHIFT, DONE);
  - `AUDIO_DATA_W = 32`;
  - `cnt_w()` helper.
- One sub-module, `lrclk_edge_det`. It registers `i_lrclk` and outputs a one-cycle rising pulse, and the ADC side can reuse it.

## Test plan
- Reset, then load 0xA5A5_0F0F, then an `i_lrclk` rising edge → serial stream 1010_0101_1010_0101_0000_1111_0000_1111 on consecutive cycles. `o_sample_req` pulses at k+DATA_W+1.
- Loopback into the ADC deserializer with samples 0x8000_0001 and 0x7FFF_FFFE → parallel output matches each sample exactly.
- No sample loaded before the second frame (first frame sent 0x1234_5678) → `o_underrun` pulses and 0x1234_5678 repeats. With the macro defined, all zeros are sent instead.
- Valid held high while the hold register is full → `o_data_ready` stays 0 until the next frame start. Exactly one sample is accepted per frame.
- `i_lrclk` rising edge 10 cycles into a frame → `o_frame_err` pulses and the frame completes unchanged.
- `i_rst_n` asserted at bit 15 → outputs return to their reset values at once. The next frame after release is an underrun sending 0.
